// File: rtl/rv32i_pkg.sv
// Shared RV32 encodings: ALU op selects, M-extension op codes used by the
// multiply/divide sequencer, and the sequencer state enumeration.
package rv32i_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] MDU_MUL  = 2'b00;
    localparam logic [1:0] MDU_DIVU = 2'b01;
    localparam logic [1:0] MDU_REMU = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_STEP = 3'd1,
        DIV_CMP  = 3'd2,
        DIV_SUB  = 3'd3,
        DONE     = 3'd4
    } mdu_state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned MUL/DIVU/REMU sequencer that borrows the shared ALU for
// one operation per cycle; shift-and-add multiply, restoring divide.
module alu_muldiv_seq
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] alu_data1,
    output logic [XLEN-1:0] alu_data2,
    input  logic [XLEN-1:0] alu_result
);

    mdu_state_t      state_reg, state_next;
    logic [1:0]      op_reg, op_next;
    logic [4:0]      cnt_reg, cnt_next;
    logic [XLEN-1:0] acc_reg, acc_next;       // product accumulator / partial remainder
    logic [XLEN-1:0] a_reg, a_next;           // multiplicand / dividend (shifted)
    logic [XLEN-1:0] b_reg, b_next;           // multiplier (shifted) / divisor
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [XLEN-1:0] rs_reg, rs_next;
    logic            ge_reg, ge_next;
    logic            last_reg, last_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [XLEN-1:0] rs_calc;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == DONE);
    assign resp_data  = resp_valid ? result_reg : '0;

    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        quo_next    = quo_reg;
        rs_next     = rs_reg;
        ge_next     = ge_reg;
        last_next   = last_reg;
        result_next = result_reg;
        alu_op      = ALU_ADD;
        alu_data1   = '0;
        alu_data2   = '0;
        rs_calc     = {acc_reg[XLEN-2:0], a_reg[XLEN-1]};

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    op_next   = req_op;
                    a_next    = req_a;
                    b_next    = req_b;
                    cnt_next  = '0;
                    acc_next  = '0;
                    quo_next  = '0;
                    last_next = 1'b0;
                    case (req_op)
                        MDU_MUL:            state_next = MUL_STEP;
                        MDU_DIVU, MDU_REMU: state_next = DIV_CMP;
                        default: begin
                            result_next = '0;
                            state_next  = DONE;
                        end
                    endcase
                end
            end

            MUL_STEP: begin
                // The cycle after the 32nd add only publishes the final sum.
                if (last_reg) begin
                    result_next = acc_reg;
                    last_next   = 1'b0;
                    state_next  = DONE;
                end else begin
                    alu_op    = ALU_ADD;
                    alu_data1 = acc_reg;
                    alu_data2 = b_reg[0] ? a_reg : '0;
                    acc_next  = alu_result;
                    a_next    = a_reg << 1;
                    b_next    = b_reg >> 1;
                    cnt_next  = cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31)
                        last_next = 1'b1;
                end
            end

            DIV_CMP: begin
                if (last_reg) begin
                    result_next = (op_reg == MDU_REMU) ? acc_reg : quo_reg;
                    last_next   = 1'b0;
                    state_next  = DONE;
                end else begin
                    // The bit shifted out of rem makes the true remainder 33 bits,
                    // so it always exceeds a 32-bit divisor.
                    alu_op     = ALU_SLTU;
                    alu_data1  = rs_calc;
                    alu_data2  = b_reg;
                    rs_next    = rs_calc;
                    ge_next    = acc_reg[XLEN-1] | ~alu_result[0];
                    a_next     = a_reg << 1;
                    state_next = DIV_SUB;
                end
            end

            DIV_SUB: begin
                alu_op     = ALU_SUB;
                alu_data1  = rs_reg;
                alu_data2  = ge_reg ? b_reg : '0;
                acc_next   = alu_result;
                quo_next   = {quo_reg[XLEN-2:0], ge_reg};
                cnt_next   = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31)
                    last_next = 1'b1;
                state_next = DIV_CMP;
            end

            DONE: begin
                if (resp_ready)
                    state_next = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            quo_reg    <= '0;
            rs_reg     <= '0;
            ge_reg     <= 1'b0;
            last_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            quo_reg    <= quo_next;
            rs_reg     <= rs_next;
            ge_reg     <= ge_next;
            last_reg   <= last_next;
            result_reg <= result_next;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a small behavioural ALU standing in
// for the shared execute-stage ALU.
module tb_alu_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  alu_op;
    logic [31:0] alu_data1;
    logic [31:0] alu_data2;
    logic [31:0] alu_result;

    int vec_count = 0;
    int err_count = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            4'b0000: alu_result = alu_data1 + alu_data2;
            4'b0001: alu_result = alu_data1 - alu_data2;
            4'b0100: alu_result = {31'd0, (alu_data1 < alu_data2)};
            default: alu_result = 32'd0;
        endcase
    end

    alu_muldiv_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .alu_op     (alu_op),
        .alu_data1  (alu_data1),
        .alu_data2  (alu_data2),
        .alu_result (alu_result)
    );

    // Presents one request, then counts edges after the accepting edge until
    // resp_valid is seen (-1 if it never comes within the budget).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] data);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        data = resp_data;
        $display("op=%0d a=%h b=%h -> data=%h latency=%0d", op, a, b, data, lat);
    endtask

    task automatic ack();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_count++;
        if (req_ready !== 1'b1) begin err_count++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        vec_count++;
        if (resp_valid !== 1'b0) begin err_count++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        vec_count++;
        if (resp_data !== 32'd0) begin err_count++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
        vec_count++;
        if ({alu_op, alu_data1, alu_data2} !== 68'd0) begin
            err_count++;
            $display("FAIL reset_alu got op=%h d1=%h d2=%h want 0/0/0", alu_op, alu_data1, alu_data2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] d;
        issue(2'b00, 32'd7, 32'd6, lat, d);
        vec_count++;
        if (d !== 32'd42) begin err_count++; $display("FAIL mul_7x6 got=%h want=%h", d, 32'd42); end
        vec_count++;
        if (lat != 33) begin err_count++; $display("FAIL mul_latency got=%0d want=33", lat); end
        ack();
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, d);
        vec_count++;
        if (d !== 32'h0000_0001) begin err_count++; $display("FAIL mul_ffxff got=%h want=00000001", d); end
        ack();
        issue(2'b00, 32'h0001_0003, 32'h0000_0100, lat, d);
        vec_count++;
        if (d !== 32'h0100_0300) begin err_count++; $display("FAIL mul_shift got=%h want=01000300", d); end
        ack();
    endtask

    task automatic test_div();
        int lat;
        logic [31:0] d;
        issue(2'b01, 32'd100, 32'd7, lat, d);
        vec_count++;
        if (d !== 32'd14) begin err_count++; $display("FAIL divu_100_7 got=%h want=%h", d, 32'd14); end
        vec_count++;
        if (lat != 65) begin err_count++; $display("FAIL divu_latency got=%0d want=65", lat); end
        ack();
        issue(2'b10, 32'd100, 32'd7, lat, d);
        vec_count++;
        if (d !== 32'd2) begin err_count++; $display("FAIL remu_100_7 got=%h want=%h", d, 32'd2); end
        vec_count++;
        if (lat != 65) begin err_count++; $display("FAIL remu_latency got=%0d want=65", lat); end
        ack();
        issue(2'b01, 32'h0000_1234, 32'd0, lat, d);
        vec_count++;
        if (d !== 32'hFFFF_FFFF) begin err_count++; $display("FAIL divu_by_zero got=%h want=ffffffff", d); end
        ack();
        issue(2'b10, 32'h0000_1234, 32'd0, lat, d);
        vec_count++;
        if (d !== 32'h0000_1234) begin err_count++; $display("FAIL remu_by_zero got=%h want=00001234", d); end
        ack();
        issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, lat, d);
        vec_count++;
        if (d !== 32'd1) begin err_count++; $display("FAIL divu_carry got=%h want=00000001", d); end
        ack();
        issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, lat, d);
        vec_count++;
        if (d !== 32'h7FFF_FFFE) begin err_count++; $display("FAIL remu_carry got=%h want=7ffffffe", d); end
        ack();
    endtask

    task automatic test_reserved();
        int lat;
        logic [31:0] d;
        issue(2'b11, 32'hDEAD_BEEF, 32'h1234_5678, lat, d);
        vec_count++;
        if (d !== 32'd0) begin err_count++; $display("FAIL reserved_data got=%h want=0", d); end
        vec_count++;
        if (lat != 1) begin err_count++; $display("FAIL reserved_latency got=%0d want=1", lat); end
        ack();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] d;
        issue(2'b00, 32'd3, 32'd4, lat, d);
        vec_count++;
        if (d !== 32'd12) begin err_count++; $display("FAIL bp_mul got=%h want=0000000c", d); end
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b11;
        req_a     = 32'h5555_5555;
        req_b     = 32'hAAAA_AAAA;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vec_count++;
            if (resp_valid !== 1'b1 || resp_data !== 32'd12 || req_ready !== 1'b0) begin
                err_count++;
                $display("FAIL bp_hold cycle=%0d got valid=%b data=%h ready=%b want 1/0000000c/0",
                         i, resp_valid, resp_data, req_ready);
            end
        end
        $display("backpressure held 10 cycles");
        @(negedge clk);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        vec_count++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            err_count++;
            $display("FAIL bp_release got valid=%b ready=%b want 0/1", resp_valid, req_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        vec_count++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            err_count++;
            $display("FAIL bp_ignored_req got valid=%b ready=%b want 0/1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [31:0] d;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 32'd1000;
        req_b     = 32'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vec_count++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'd0 ||
            {alu_op, alu_data1, alu_data2} !== 68'd0) begin
            err_count++;
            $display("FAIL midreset_state got ready=%b valid=%b data=%h op=%h d1=%h d2=%h want 1/0/0/0/0/0",
                     req_ready, resp_valid, resp_data, alu_op, alu_data1, alu_data2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        vec_count++;
        if (seen != 0) begin err_count++; $display("FAIL midreset_no_resp got=%0d cycles valid want=0", seen); end
        $display("reset mid-DIVU, then idle 70 cycles");
        issue(2'b00, 32'd3, 32'd5, lat, d);
        vec_count++;
        if (d !== 32'd15) begin err_count++; $display("FAIL midreset_mul got=%h want=0000000f", d); end
        vec_count++;
        if (lat != 33) begin err_count++; $display("FAIL midreset_mul_latency got=%0d want=33", lat); end
        ack();
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_reserved();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that computes RV32M-subset unsigned MUL, DIVU and REMU by driving the shared 32-bit ALU iteratively: one ALU operation per cycle, with shifts and bookkeeping in local registers. It sits beside the execute stage. It takes ownership of the ALU operand and opcode inputs while busy, and returns a single 32-bit result through a valid/ready handshake. The ALU stays a separate combinational instance; this block only sequences it.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  2  operation: 00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved.
- req_a  in  32  multiplicand or dividend.
- req_b  in  32  multiplier or divisor.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  32  result.
- alu_op  out  4  ALU operation select.
- alu_data1  out  32  ALU operand 1.
- alu_data2  out  32  ALU operand 2.
- alu_result  in  32  ALU result, combinational from the alu_* outputs.

## Operation
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch the operands and op, clear cnt (5-bit) and acc/rem, then go to MUL_STEP (op 00), DIV_CMP (01/10) or DONE with result 0 (11).
- MUL_STEP, 32 cycles:
  - alu_op=ADD, alu_data1=acc, alu_data2 = mplier[0] ? mcand : 0.
  - Register: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt++.
  - After cnt==31, result<=acc, go to DONE.
  - Overflow bits are discarded (modulo 2^32).
- DIV_CMP (restoring division, MSB first):
  - Form rs = {rem[30:0], dvd[31]} and carry c = rem[31].
  - alu_op=SLTU, alu_data1=rs, alu_data2=divisor.
  - ge = c | ~alu_result[0]; register rs, ge and the shifted dvd.
- DIV_SUB:
  - alu_op=SUB, alu_data1=rs, alu_data2 = ge ? divisor : 0.
  - rem<=alu_result (32-bit wrap is correct when c=1), quo<={quo[30:0], ge}, cnt++.
  - After cnt==31 go to DONE with result quo (DIVU) or rem (REMU); otherwise return to DIV_CMP.
- Divide by zero needs no special case. Every ge is 1, so DIVU gives 0xFFFFFFFF and REMU gives req_a, matching RISC-V.
- DONE:
  - resp_valid=1 and resp_data=result, both held stable until resp_ready.
  - On resp_ready go to IDLE.
  - A new request cannot be accepted in the same cycle (req_ready=0 in DONE).
- ALU outputs in IDLE and DONE: alu_op=ADD, alu_data1=alu_data2=0.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, alu_op=ADD (0000), alu_data1=alu_data2=0, cnt=0.
- Latency is fixed and data-independent. With the accepting edge as E0, resp_valid rises after:
  - E0+33 for MUL (32 steps + DONE entry);
  - E0+65 for DIVU/REMU (64 cycles);
  - E0+1 for the reserved op.
- Throughput is one operation per latency+1 cycles at minimum: one idle cycle after the response handshake.
- alu_* outputs are combinational from the current state and registers. alu_result is sampled in the same cycle, so there is no pipelining.
- cnt wraps 31→0 exactly at the exit of the final step.
- Backpressure: DONE persists indefinitely while resp_ready=0. Inputs on req_* are ignored outside IDLE.
- Reset mid-operation: the next edge with rst_n=0 returns the block to IDLE with every output at its reset value. Partial results are discarded and no response is issued.

## Structure
- Shared package rv32i_pkg holds:
  - the ALU opcode constants ADD=0000, SUB=0001, SLTU=0100 and the rest of the ALU op set;
  - the MDU op codes MUL=00, DIVU=01, REMU=10;
  - the state enumeration.
- Single module with no sub-module. The ALU is instantiated by the parent, which muxes the alu_* outputs onto the shared ALU while resp_valid or ~req_ready.

## Test plan
- MUL a=7, b=6 → resp_data=42, resp_valid at E0+33. Also MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2; resp_valid at E0+65 for both.
- Divide by zero: DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x00001234.
- Carry path: DIVU 0xFFFFFFFF/0x80000001 → 1; REMU → 0x7FFFFFFE.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE → resp_data stable, req_ready=0, a concurrent req_valid is ignored. Then resp_ready=1 → IDLE on the next edge.
- Reset mid-DIVU (rst_n=0 at E0+20) → IDLE next edge, resp_valid never asserted. A following MUL 3×5 → 15 at the normal latency.
